// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit (MULT/MULTU/DIV/DIVU), one bit per cycle, HI/LO result registers.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d, zb_q, zb_d, dbz_q, dbz_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod, prod_s;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     trial, sum;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
    logic               sgn_a, sgn_b;

    assign sgn_a = ~op[0] & a[WIDTH-1];
    assign sgn_b = ~op[0] & b[WIDTH-1];
    assign mag_a = sgn_a ? -a : a;
    assign mag_b = sgn_b ? -b : b;

    // Divide: acc = {remainder, dividend/quotient}; trial subtract of {rem, next dividend bit}.
    assign trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    // Multiply: acc upper half accumulates, whole acc shifts right one bit per cycle.
    assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){b_q[0]}});

`ifdef MULDIV_EARLY_OUT_EN
    assign prod = acc_q >> cnt_q;
`else
    assign prod = acc_q;
`endif
    assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
    assign quo    = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem    = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        zb_d    = zb_q;
        dbz_d   = dbz_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    sa_d    = sgn_a;
                    sb_d    = sgn_b;
                    a_d     = mag_a;
                    b_d     = mag_b;
                    acc_d   = op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
                    cnt_d   = CNT_W'(WIDTH);
                    zb_d    = op[1] & (b == '0);
                    dbz_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (zb_q) begin
                    // a_q holds |a|; restore the raw dividend for hi.
                    hi_d    = sa_q ? -a_q : a_q;
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q[1]) begin
                        acc_d = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                             : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {sum, acc_q[WIDTH-1:1]};
                        b_d   = b_q >> 1;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    else if (!op_q[1] && (b_q >> 1) == '0) begin
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_FIX: begin
                if (op_q[1]) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    {hi_d, lo_d} = prod_s;
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            zb_q    <= 1'b0;
            dbz_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            zb_q    <= zb_d;
            dbz_q   <= dbz_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors with literal results, plus an arithmetic model checked every cycle.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT1 = 5;
`else
    localparam int LAT1 = 34;
`endif

    logic          clock, reset, start;
    logic [1:0]    op;
    logic [W-1:0]  a, b, hi, lo;
    logic          busy, done, div_by_zero;
    logic [1:0]    state_out;

    int errs = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero), .state_out(state_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            if (errs <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Result per MIPS semantics, computed with plain 64-bit arithmetic: {dbz, hi, lo}.
    function automatic logic [2*W:0] model_fn(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        logic [63:0] v, vq, vr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (o[1] && y == '0) return {1'b1, x, {W{1'b1}}};
        case (o)
            2'd0: v = sx * sy;
            2'd1: v = ux * uy;
            2'd2: begin q = sx / sy; r = sx % sy; vq = q; vr = r; v = {vr[31:0], vq[31:0]}; end
            default: begin vq = ux / uy; vr = ux % uy; v = {vr[31:0], vq[31:0]}; end
        endcase
        return {1'b0, v};
    endfunction

    // Cycles from accept to the done cycle (accept cycle excluded).
    function automatic int lat_of(input logic [1:0] o, input logic [W-1:0] y);
        if (o[1] && y == '0) return 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) begin
            logic [W-1:0] m;
            int bl;
            m = (!o[0] && y[W-1]) ? -y : y;
            bl = 1;
            for (int i = 0; i < W; i++) if (m[i]) bl = i + 1;
            return bl + 2;
        end
`endif
        return W + 2;
    endfunction

    // Reference: tracks whether an op is in flight and which cycle of it we are in.
    logic         m_busy, m_dbz, m_zop, r_dbz;
    int           m_cnt, m_lat;
    logic [W-1:0] m_hi, m_lo, r_hi, r_lo;

    always @(posedge clock) begin
        if (!reset) begin
            m_busy <= 1'b0; m_cnt <= 0; m_lat <= 0; m_zop <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_dbz <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_dbz  <= 1'b0;
                m_lat  <= lat_of(op, b);
                m_zop  <= op[1] && (b == '0);
                {r_dbz, r_hi, r_lo} <= model_fn(op, a, b);
            end
        end else if (m_cnt == m_lat) begin
            m_busy <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) begin
                m_hi <= r_hi; m_lo <= r_lo; m_dbz <= r_dbz;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            logic [1:0] es;
            if (!m_busy)                es = 2'b00;
            else if (m_cnt == m_lat)    es = 2'b11;
            else if (m_zop)             es = 2'b01;
            else if (m_cnt == m_lat - 1) es = 2'b10;
            else                        es = 2'b01;
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("cyc_done", {31'b0, done}, {31'b0, m_busy && m_cnt == m_lat});
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
            chk("cyc_dbz", {31'b0, div_by_zero}, {31'b0, m_dbz});
            chk("cyc_state", {30'b0, state_out}, {30'b0, es});
        end
    end

    task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed, input int elat);
        int n;
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        chk({nm, "_dbz_clr"}, {31'b0, div_by_zero}, 32'd0);
        while (!done && n < 3 * W) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            if (elat != 0) chk({nm, "_lat"}, n, elat);
            chk({nm, "_hi"}, hi, eh);
            chk({nm, "_lo"}, lo, el);
            chk({nm, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ed});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        chk("rst_state", {30'b0, state_out}, 32'd0);
        chk_en = 1'b1;

        run_op("mult_neg3x7",  2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, LAT1);
        run_op("multu_max",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
        run_op("mult_m1xm1",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 0);
        run_op("mult_minxmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0);
        run_op("mult_maxx2",   2'b00, 32'h7FFFFFFF, 32'd2,        32'h00000000, 32'hFFFFFFFE, 1'b0, 0);
        run_op("multu_x0",     2'b01, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 1'b0, 0);
        run_op("div_neg7by2",  2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
        run_op("div_7byneg2",  2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
        run_op("divu_100by7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 0);
        run_op("divu_by0",     2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 2);
        run_op("divu_after0",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 0);
        run_op("div_ovf",      2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0);
        run_op("div_by0_neg",  2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 2);
        run_op("divu_big",     2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0, 0);

        // Reset mid-RUN with start held high throughout.
        @(negedge clock);
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd3;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_state", {30'b0, state_out}, 32'd0);
        n = 0;
        while (!done && n < 3 * W) begin
            @(negedge clock);
            n++;
        end
        chk("held_done_seen", {31'b0, done}, 32'd1);
        chk("held_lo", lo, 32'd15);
        @(negedge clock);
        chk("held_idle_gap", {30'b0, state_out}, 32'd0);
        @(negedge clock);
        chk("held_reaccept", {31'b0, busy}, 32'd1);
        start = 1'b0;
        n = 0;
        while (!done && n < 3 * W) begin
            @(negedge clock);
            n++;
        end
        chk("held2_done_seen", {31'b0, done}, 32'd1);
        chk("held2_hi", hi, 32'd0);
        chk("held2_lo", lo, 32'd15);
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
